// File: rtl/i2cmb_txn_sequencer.sv
// Wishbone master that runs one complete single-byte I2C transaction at a time
// on the iicmb_m_wb controller: bus select, start, address, data/read, stop.
module i2cmb_txn_sequencer #(
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned NUM_I2C_BUSSES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rw_i,
    input  logic [3:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic [7:0]               req_data_i,
    output logic                     rsp_valid_o,
    output logic [1:0]               rsp_status_o,
    output logic [7:0]               rsp_data_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // One bit per 4-bit bus id: set when the id exists behind the controller
    localparam logic [15:0] BUS_MASK = (NUM_I2C_BUSSES >= 16) ? 16'hFFFF
                                     : 16'((32'd1 << NUM_I2C_BUSSES) - 32'd1);

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [1:0] STS_OK  = 2'd0;
    localparam logic [1:0] STS_NAK = 2'd1;
    localparam logic [1:0] STS_AL  = 2'd2;
    localparam logic [1:0] STS_ERR = 2'd3;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_DPR, S_CMDR, S_WAIT, S_RDCMDR, S_RDDPR, S_TO_OFF, S_TO_ON, S_RESP
    } state_t;

    typedef enum logic [2:0] {
        ST_SETBUS, ST_START, ST_ADDR, ST_DATA, ST_RDNAK, ST_STOP
    } step_t;

    state_t             state_q;
    step_t              step_q;
    logic               ready_q;
    logic               rw_q;
    logic [3:0]         bus_q;
    logic [6:0]         addr_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rdata_q;
    logic [1:0]         sts_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cyc_q;
    logic               we_q;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic               rsp_valid_q;
    logic [1:0]         rsp_status_q;
    logic [7:0]         rsp_data_q;

    logic               acc_c;
    logic               acc_we_c;
    logic [WB_ADDR_WIDTH-1:0] acc_adr_c;
    logic [7:0]         acc_byte_c;
    logic               ack_done_c;
    logic [7:0]         rd_byte_c;

    // Wishbone access descriptor for the current state
    always_comb begin
        acc_c      = 1'b1;
        acc_we_c   = 1'b1;
        acc_adr_c  = ADR_CMDR;
        acc_byte_c = 8'h00;
        case (state_q)
            S_INIT, S_TO_ON: begin
                acc_adr_c  = ADR_CSR;
                acc_byte_c = 8'hC0;
            end
            S_TO_OFF: acc_adr_c = ADR_CSR;
            S_DPR: begin
                acc_adr_c = ADR_DPR;
                case (step_q)
                    ST_SETBUS: acc_byte_c = {4'h0, bus_q};
                    ST_ADDR:   acc_byte_c = {addr_q, rw_q};
                    ST_DATA:   acc_byte_c = wdata_q;
                    default:   acc_byte_c = 8'h00;
                endcase
            end
            S_CMDR: begin
                case (step_q)
                    ST_SETBUS: acc_byte_c = 8'h06;
                    ST_START:  acc_byte_c = 8'h04;
                    ST_ADDR:   acc_byte_c = 8'h01;
                    ST_DATA:   acc_byte_c = 8'h01;
                    ST_RDNAK:  acc_byte_c = 8'h03;
                    ST_STOP:   acc_byte_c = 8'h05;
                    default:   acc_byte_c = 8'h00;
                endcase
            end
            S_RDCMDR: acc_we_c = 1'b0;
            S_RDDPR: begin
                acc_we_c  = 1'b0;
                acc_adr_c = ADR_DPR;
            end
            default: acc_c = 1'b0;
        endcase
    end

    assign ack_done_c = cyc_q && ack_i;
    assign rd_byte_c  = 8'(dat_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_INIT;
            step_q       <= ST_SETBUS;
            ready_q      <= 1'b0;
            rw_q         <= 1'b0;
            bus_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            sts_q        <= STS_OK;
            cnt_q        <= '0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= STS_OK;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (acc_c && !cyc_q) begin
                cyc_q <= 1'b1;
                we_q  <= acc_we_c;
                adr_q <= acc_adr_c;
                dat_q <= WB_DATA_WIDTH'(acc_byte_c);
            end
            if (ack_done_c) begin
                cyc_q <= 1'b0;
            end
            case (state_q)
                S_INIT: begin
                    if (ack_done_c) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        rw_q    <= req_rw_i;
                        bus_q   <= req_bus_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_data_i;
                        rdata_q <= 8'h00;
                        step_q  <= ST_SETBUS;
                        if (BUS_MASK[req_bus_i]) begin
                            sts_q   <= STS_OK;
                            state_q <= S_DPR;
                        end else begin
                            sts_q   <= STS_ERR;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_DPR: begin
                    if (ack_done_c) state_q <= S_CMDR;
                end
                S_CMDR: begin
                    if (ack_done_c) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (irq_i) begin
                        state_q <= S_RDCMDR;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= S_TO_OFF;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Decode CMDR: AL > ERR > NAK > DON; an earlier failure status is kept
                S_RDCMDR: begin
                    if (ack_done_c) begin
                        if (rd_byte_c[5]) begin
                            sts_q   <= (sts_q == STS_OK) ? STS_AL : sts_q;
                            state_q <= S_RESP;
                        end else if (rd_byte_c[4]) begin
                            sts_q   <= (sts_q == STS_OK) ? STS_ERR : sts_q;
                            state_q <= S_RESP;
                        end else if (rd_byte_c[6]) begin
                            sts_q <= (sts_q == STS_OK) ? STS_NAK : sts_q;
                            if (step_q == ST_STOP) begin
                                state_q <= S_RESP;
                            end else begin
                                step_q  <= ST_STOP;
                                state_q <= S_CMDR;
                            end
                        end else if (rd_byte_c[7]) begin
                            case (step_q)
                                ST_SETBUS: begin
                                    step_q  <= ST_START;
                                    state_q <= S_CMDR;
                                end
                                ST_START: begin
                                    step_q  <= ST_ADDR;
                                    state_q <= S_DPR;
                                end
                                ST_ADDR: begin
                                    step_q  <= rw_q ? ST_RDNAK : ST_DATA;
                                    state_q <= rw_q ? S_CMDR : S_DPR;
                                end
                                ST_DATA: begin
                                    step_q  <= ST_STOP;
                                    state_q <= S_CMDR;
                                end
                                ST_RDNAK: state_q <= S_RDDPR;
                                default:  state_q <= S_RESP;
                            endcase
                        end else begin
                            sts_q   <= (sts_q == STS_OK) ? STS_ERR : sts_q;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RDDPR: begin
                    if (ack_done_c) begin
                        rdata_q <= rd_byte_c;
                        step_q  <= ST_STOP;
                        state_q <= S_CMDR;
                    end
                end
                // Timeout: pulse the controller enable off and back on
                S_TO_OFF: begin
                    if (ack_done_c) state_q <= S_TO_ON;
                end
                S_TO_ON: begin
                    if (ack_done_c) begin
                        sts_q   <= STS_ERR;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_status_q <= sts_q;
                    rsp_data_q   <= (sts_q == STS_OK) ? rdata_q : 8'h00;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_data_o   = rsp_data_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_i2cmb_txn_sequencer.sv
// Bench for i2cmb_txn_sequencer: a behavioural iicmb controller answers Wishbone
// accesses; table-driven transactions plus reset/init sequences.
module tb_i2cmb_txn_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] rsp_data;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack;
    logic       irq;

    i2cmb_txn_sequencer #(
        .WB_ADDR_WIDTH (2),
        .WB_DATA_WIDTH (8),
        .NUM_I2C_BUSSES(15),
        .TIMEOUT_CYCLES(40)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rw_i    (req_rw),
        .req_bus_i   (req_bus),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_status_o(rsp_status),
        .rsp_data_o  (rsp_data),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack),
        .irq_i       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] went(input int a, input int d);
        return {2'(a), 8'(d)};
    endfunction

    // Controller model state
    logic [9:0]  wlog[$];
    int          n_rd;
    logic [47:0] rsp_vec;
    int          rsp_n, rsp_idx;
    logic [7:0]  dpr_rd;
    int          irq_dly, irq_cnt;
    bit          irq_block, irq_pend;
    int          proto_err = 0;
    int          rsp_cnt = 0;

    initial begin
        ack = 1'b0; dat_i = 8'h00; irq = 1'b0; irq_pend = 1'b0; irq_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ack = 1'b0; irq = 1'b0; irq_pend = 1'b0;
            end else begin
                if (irq_pend) begin
                    if (irq_cnt == 0) begin irq = 1'b1; irq_pend = 1'b0; end
                    else irq_cnt--;
                end
                if (ack) begin
                    ack = 1'b0;
                end else if (cyc_o && stb_o) begin
                    if (we_o) begin
                        wlog.push_back({adr_o, dat_o});
                        if (adr_o == 2'd2 && !irq_block) begin
                            if (irq_dly == 0) irq = 1'b1;
                            else begin irq_pend = 1'b1; irq_cnt = irq_dly - 1; end
                        end
                    end else begin
                        n_rd++;
                        if (adr_o == 2'd2) begin
                            dat_i = (rsp_idx < rsp_n) ? rsp_vec[8*(rsp_n-1-rsp_idx) +: 8] : 8'h80;
                            rsp_idx++;
                            irq = 1'b0;
                        end else begin
                            dat_i = dpr_rd;
                        end
                    end
                    ack = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc_o !== stb_o) proto_err++;
            if (rsp_valid === 1'b1) rsp_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic        rw;
        logic [3:0]  bus;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [7:0]  dpr;
        logic [3:0]  n_rsp;
        logic [47:0] rsp;
        logic [3:0]  irq_dly;
        logic        irq_block;
        logic [1:0]  exp_status;
        logic [7:0]  exp_data;
        logic [3:0]  n_wr;
        logic [79:0] exp_wr;
    } vec_t;

    function automatic vec_t mkv(input bit rw, input int bus, input int addr, input int data,
                                 input int dpr, input int n_rsp, input logic [47:0] rsp,
                                 input int dly, input bit blk, input int st, input int dat,
                                 input int n_wr, input logic [79:0] wr);
        vec_t v;
        v.rw = rw; v.bus = 4'(bus); v.addr = 7'(addr); v.data = 8'(data); v.dpr = 8'(dpr);
        v.n_rsp = 4'(n_rsp); v.rsp = rsp; v.irq_dly = 4'(dly); v.irq_block = blk;
        v.exp_status = 2'(st); v.exp_data = 8'(dat); v.n_wr = 4'(n_wr); v.exp_wr = wr;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vt[NV];

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1'b1;
        end
    endtask

    function automatic logic [79:0] pack_log();
        logic [79:0] a = '0;
        foreach (wlog[k]) a = {a[69:0], wlog[k]};
        return a;
    endfunction

    task automatic run_vec(input int i);
        vec_t v = vt[i];
        bit ok, got;
        rsp_vec = v.rsp; rsp_n = int'(v.n_rsp); rsp_idx = 0; dpr_rd = v.dpr;
        irq_dly = int'(v.irq_dly); irq_block = v.irq_block;
        wlog.delete();
        wait_ready(ok);
        chk($sformatf("v%0d_ready", i), 80'(ok), 80'(1));
        req_rw = v.rw; req_bus = v.bus; req_addr = v.addr; req_data = v.data; req_valid = 1'b1;
        @(posedge clk); #1;
        // Keep valid high with different fields while busy
        req_bus = ~v.bus; req_addr = ~v.addr; req_data = ~v.data; req_rw = ~v.rw;
        @(negedge clk);
        chk($sformatf("v%0d_ready_drop", i), 80'(req_ready), 80'(0));
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        req_valid = 1'b0;
        chk($sformatf("v%0d_rsp_seen", i), 80'(got), 80'(1));
        if (got) begin
            chk($sformatf("v%0d_status", i), 80'(rsp_status), 80'(v.exp_status));
            chk($sformatf("v%0d_data", i), 80'(rsp_data), 80'(v.exp_data));
            chk($sformatf("v%0d_nwr", i), 80'(wlog.size()), 80'(v.n_wr));
            chk($sformatf("v%0d_wseq", i), pack_log(), v.exp_wr);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 80'(rsp_valid), 80'(0));
        end
        irq_block = 1'b0;
    endtask

    initial begin
        bit ok, found;
        int rc;
        vt[0]  = mkv(0, 5, 'h22, 'hA5, 0, 5, 48'({8'h80, 8'h80, 8'h80, 8'h80, 8'h80}), 2, 0, 0, 0, 8,
                     80'({went(1,'h05), went(2,'h06), went(2,'h04), went(1,'h44), went(2,'h01),
                          went(1,'hA5), went(2,'h01), went(2,'h05)}));
        vt[1]  = mkv(1, 0, 'h10, 0, 'h3C, 5, 48'({8'h80, 8'h80, 8'h80, 8'h80, 8'h80}), 0, 0, 0, 'h3C, 7,
                     80'({went(1,'h00), went(2,'h06), went(2,'h04), went(1,'h21), went(2,'h01),
                          went(2,'h03), went(2,'h05)}));
        vt[2]  = mkv(0, 3, 'h50, 'h77, 0, 4, 48'({8'h80, 8'h80, 8'h40, 8'h80}), 1, 0, 1, 0, 6,
                     80'({went(1,'h03), went(2,'h06), went(2,'h04), went(1,'hA0), went(2,'h01),
                          went(2,'h05)}));
        vt[3]  = mkv(0, 1, 'h33, 'h11, 0, 2, 48'({8'h80, 8'h20}), 3, 0, 2, 0, 3,
                     80'({went(1,'h01), went(2,'h06), went(2,'h04)}));
        vt[4]  = mkv(1, 2, 'h7F, 0, 'h99, 4, 48'({8'h80, 8'h80, 8'h40, 8'h80}), 0, 0, 1, 0, 6,
                     80'({went(1,'h02), went(2,'h06), went(2,'h04), went(1,'hFF), went(2,'h01),
                          went(2,'h05)}));
        vt[5]  = mkv(0, 9, 'h01, 'h02, 0, 1, 48'(8'h10), 0, 0, 3, 0, 2,
                     80'({went(1,'h09), went(2,'h06)}));
        vt[6]  = mkv(0, 4, 'h01, 'h02, 0, 2, 48'({8'h80, 8'hF0}), 0, 0, 2, 0, 3,
                     80'({went(1,'h04), went(2,'h06), went(2,'h04)}));
        vt[7]  = mkv(0, 6, 'h2A, 'h55, 0, 4, 48'({8'h80, 8'h80, 8'h40, 8'h20}), 1, 0, 1, 0, 6,
                     80'({went(1,'h06), went(2,'h06), went(2,'h04), went(1,'h54), went(2,'h01),
                          went(2,'h05)}));
        vt[8]  = mkv(0, 7, 'h08, 'hC3, 0, 5, 48'({8'h80, 8'h80, 8'h80, 8'h80, 8'h40}), 0, 0, 1, 0, 8,
                     80'({went(1,'h07), went(2,'h06), went(2,'h04), went(1,'h10), went(2,'h01),
                          went(1,'hC3), went(2,'h01), went(2,'h05)}));
        vt[9]  = mkv(1, 8, 'h45, 0, 'h5A, 5, 48'({8'h80, 8'h80, 8'h80, 8'h80, 8'h10}), 2, 0, 3, 0, 7,
                     80'({went(1,'h08), went(2,'h06), went(2,'h04), went(1,'h8B), went(2,'h01),
                          went(2,'h03), went(2,'h05)}));
        vt[10] = mkv(0, 10, 'h3C, 'h01, 0, 4, 48'({8'h80, 8'h80, 8'hC0, 8'h80}), 0, 0, 1, 0, 6,
                     80'({went(1,'h0A), went(2,'h06), went(2,'h04), went(1,'h78), went(2,'h01),
                          went(2,'h05)}));
        vt[11] = mkv(0, 15, 'h11, 'h22, 0, 0, 48'(0), 0, 0, 3, 0, 0, 80'(0));
        vt[12] = mkv(0, 14, 'h11, 'h22, 0, 0, 48'(0), 0, 1, 3, 0, 4,
                     80'({went(1,'h0E), went(2,'h06), went(0,'h00), went(0,'hC0)}));
        vt[13] = mkv(1, 14, 'h01, 0, 'hE7, 0, 48'(0), 1, 0, 0, 'hE7, 7,
                     80'({went(1,'h0E), went(2,'h06), went(2,'h04), went(1,'h03), went(2,'h01),
                          went(2,'h03), went(2,'h05)}));

        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_bus = '0; req_addr = '0; req_data = '0;
        rsp_n = 0; rsp_idx = 0; rsp_vec = '0; dpr_rd = '0; irq_dly = 0; irq_block = 1'b0; n_rd = 0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", 80'({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid,
                                  rsp_status, rsp_data}), 80'(0));
        wlog.delete();
        rst_n = 1'b1;
        wait_ready(ok);
        chk("init_ready", 80'(ok), 80'(1));
        chk("init_nwr", 80'(wlog.size()), 80'(1));
        chk("init_wseq", pack_log(), 80'(went(0, 'hC0)));
        chk("init_nrd", 80'(n_rd), 80'(0));

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while the DATA command write is on the bus
        rsp_n = 0; rsp_idx = 0; irq_dly = 1; irq_block = 1'b0;
        wlog.delete();
        wait_ready(ok);
        req_rw = 1'b0; req_bus = 4'd5; req_addr = 7'h22; req_data = 8'hA5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (cyc_o && we_o && adr_o == 2'd2 && wlog.size() == 7) found = 1'b1;
        end
        chk("mid_data_reached", 80'(found), 80'(1));
        rc = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_cyc_drop", 80'({cyc_o, stb_o}), 80'(0));
        repeat (3) @(negedge clk);
        wlog.delete(); n_rd = 0;
        rst_n = 1'b1;
        wait_ready(ok);
        chk("reinit_ready", 80'(ok), 80'(1));
        chk("reinit_wseq", {70'(0), 10'(wlog.size()), 80'(0)} == 0 ? 80'(0) : pack_log(),
            80'(went(0, 'hC0)));
        chk("reinit_nwr", 80'(wlog.size()), 80'(1));
        chk("reset_no_rsp", 80'(rsp_cnt - rc), 80'(0));

        chk("cyc_eq_stb", 80'(proto_err), 80'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
